// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM states, default widths and the single GF(2) division step
// used by both the encoder and the decoder.
package crc_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} crc_state_e;

    localparam int CRC_CODEWIDTH = 10;
    localparam int CRC_CRCWIDTH  = 4;
    localparam int CRC_MAX_W     = 32;

    // One long-division step on a width-bit remainder held in the low bits of a
    // CRC_MAX_W container; the generator's leading 1 is implied by the MSB test.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] rem,
        input logic                 b,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   width
    );
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] shifted;
        logic                 msb;
        mask    = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - width);
        msb     = |(rem & mask & ~(mask >> 1));
        shifted = ((rem << 1) | {{(CRC_MAX_W-1){1'b0}}, b}) & mask;
        if (msb) begin
            shifted = shifted ^ (poly & mask);
        end
        return shifted;
    endfunction

endpackage

// File: rtl/crc_decoder.sv
// Serial CRC checker: divides a received codeword by the generator one bit per clock
// and reports the syndrome, an error flag and the extracted message.
module crc_decoder
    import crc_pkg::*;
#(
    parameter int CODEWIDTH = CRC_CODEWIDTH,
    parameter int CRCWIDTH  = CRC_CRCWIDTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [CODEWIDTH-1:0]          codeword,
    input  logic [CRCWIDTH:0]             genPoly,
    output logic                          ready,
    output logic                          done,
    output logic [CRCWIDTH-1:0]           syndrome,
    output logic                          crc_err,
    output logic [CODEWIDTH-CRCWIDTH-1:0] dataout
);

    localparam int N     = CODEWIDTH - CRCWIDTH;
    localparam int CNT_W = $clog2(N + 1);

    crc_state_e             state_q, state_d;
    logic [CRCWIDTH-1:0]    rem_q, rem_d;
    logic [N-1:0]           sreg_q, sreg_d;
    logic [CRCWIDTH-1:0]    poly_q, poly_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N-1:0]           dataout_q, dataout_d;
    logic [CRCWIDTH-1:0]    syndrome_q, syndrome_d;
    logic                   crc_err_q, crc_err_d;

    // The generator's top coefficient is always 1 and never read.
    logic unused_poly_msb;
    assign unused_poly_msb = genPoly[CRCWIDTH];

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        sreg_d     = sreg_q;
        poly_d     = poly_q;
        cnt_d      = cnt_q;
        dataout_d  = dataout_q;
        syndrome_d = syndrome_q;
        crc_err_d  = crc_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d     = codeword[CODEWIDTH-1 -: CRCWIDTH];
                    sreg_d    = codeword[N-1:0];
                    poly_d    = genPoly[CRCWIDTH-1:0];
                    dataout_d = codeword[CODEWIDTH-1:CRCWIDTH];
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d  = CRCWIDTH'(crc_step({{(CRC_MAX_W-CRCWIDTH){1'b0}}, rem_q},
                                            sreg_q[N-1],
                                            {{(CRC_MAX_W-CRCWIDTH){1'b0}}, poly_q},
                                            CRCWIDTH));
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Results are registered on the final shift so they are valid with done.
                if (cnt_q == CNT_W'(N - 1)) begin
                    syndrome_d = rem_d;
                    crc_err_d  = |rem_d;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            sreg_q     <= '0;
            poly_q     <= '0;
            cnt_q      <= '0;
            dataout_q  <= '0;
            syndrome_q <= '0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            sreg_q     <= sreg_d;
            poly_q     <= poly_d;
            cnt_q      <= cnt_d;
            dataout_q  <= dataout_d;
            syndrome_q <= syndrome_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign syndrome = syndrome_q;
    assign crc_err  = crc_err_q;
    assign dataout  = dataout_q;

endmodule

// File: doc/crc_decoder.md
Name: crc_decoder

Overview:
- Serial CRC checker for codewords produced by the team's CRC encoder.
- Accepts a CODEWIDTH-bit codeword: message in the upper bits, CRC remainder in the low CRCWIDTH bits.
- Divides the codeword by the generator polynomial, one bit per clock, and reports the syndrome, an error flag and the extracted message.
- Sits on the receive side of the CRC link, after deserialisation and before the message consumer.

Parameters:
- CODEWIDTH, 10, total codeword bits (message + CRC); must be greater than CRCWIDTH.
- CRCWIDTH, 4, CRC/syndrome width; generator degree.

Ports:
- clk  input  1  clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request to check codeword; accepted only when ready=1.
- codeword  input  CODEWIDTH  received codeword; sampled on the accepting edge only.
- genPoly  input  CRCWIDTH+1  generator polynomial; bit CRCWIDTH is an implied 1 and is ignored; sampled on the accepting edge only.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; syndrome, crc_err and dataout valid.
- syndrome  output  CRCWIDTH  remainder of codeword mod genPoly.
- crc_err  output  1  OR-reduction of syndrome.
- dataout  output  CODEWIDTH-CRCWIDTH  message field, codeword[CODEWIDTH-1:CRCWIDTH].

Behaviour:
- Reset: all registers and outputs go to 0, except ready, which is 1 (IDLE). Reset mid-operation aborts immediately, with no done pulse.
- Let N = CODEWIDTH-CRCWIDTH. Counter width is $clog2(N+1).
- FSM states are IDLE, CALC, DONE.
- IDLE:
  - On start=1, load rem <= codeword[CODEWIDTH-1 -: CRCWIDTH].
  - Load shift register sreg <= codeword[N-1:0] and polyreg <= genPoly[CRCWIDTH-1:0].
  - Latch dataout <= codeword[CODEWIDTH-1:CRCWIDTH]; clear cnt; go to CALC.
- CALC, on each edge, with b = sreg MSB:
  - If rem MSB is 1: rem <= {rem[CRCWIDTH-2:0], b} XOR polyreg.
  - Otherwise: rem <= {rem[CRCWIDTH-2:0], b}.
  - Then sreg <= sreg << 1 and cnt++.
  - After the edge where cnt reaches N-1 (the Nth shift), go to DONE.
- DONE:
  - done=1 for exactly one cycle; syndrome=rem; crc_err=|rem.
  - Next edge goes to IDLE.
- Latency: start accepted at edge E gives done high in the cycle after edge E+N, i.e. N+1 cycles.
- syndrome, crc_err and dataout hold their values after DONE until the next accepted start.
- During the busy window (CALC/DONE), their values are unspecified but stable at the port. Checkers sample only on done.
- start while ready=0 (CALC or DONE) is ignored, with no queuing. Changes to codeword or genPoly after acceptance have no effect.
- start held high continuously means back-to-back checks: one accepted every N+2 cycles.
- genPoly low bits all zero is legal: the result is the plain remainder by x^CRCWIDTH. No special casing.
- Arithmetic is GF(2) only: XOR, no carries. syndrome is exactly CRCWIDTH bits.

Decomposition:
- Package crc_pkg holds:
  - enum crc_state_e {IDLE, CALC, DONE};
  - default CODEWIDTH and CRCWIDTH localparams, shared with the encoder;
  - a function crc_step(rem, bit, poly) returning the next remainder, so the encoder and decoder share the same division step.
- No sub-module is required. The FSM, counter and datapath live in one module, with the datapath using crc_pkg::crc_step.

Test Plan:
- Clean codeword: genPoly=5'b10011, codeword=10'h013 (message 6'b000001, CRC 4'b0011), start one cycle. Required: done exactly 7 cycles after the accepting edge; syndrome=4'h0, crc_err=0, dataout=6'h01.
- Single-bit error at bit 0: codeword=10'h012, same poly. Required: syndrome=4'h1, crc_err=1, dataout=6'h01.
- Single-bit error at bit 4: codeword=10'h003. Required: syndrome=4'h3 (x^4 mod g), crc_err=1, dataout=6'h00.
- Start while busy: accept 10'h013, then pulse start with codeword=10'h3FF two cycles later. Required: ignored; single done with syndrome=0; ready returns high the cycle after done.
- Reset mid-operation: resetn=0 for one edge at the 3rd CALC cycle. Required: no done, ready=1, all outputs 0. A subsequent 10'h012 check still gives syndrome=4'h1.
- Back-to-back with input churn: start held high with 10'h013, 10'h012 alternating each accept, and genPoly changed mid-CALC. Required: done every 8 cycles, syndromes 0,1,0,1, unaffected by the mid-calculation genPoly change.
